// File: rtl/uart_rx_cfg.sv
// rtl/uart_rx_cfg.sv - configurable UART receiver, mid-bit sampling after a 2-flop synchronizer.
// Optional parity check is built only when UART_RX_PARITY_EN is defined.
module uart_rx_cfg #(
  parameter int CLKS_PER_BIT = 434,
  parameter int DATA_BITS    = 8,
  parameter int STOP_BITS    = 1,
  parameter int PARITY_ODD   = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 Rx,
  output logic [DATA_BITS-1:0] Rx_data,
  output logic                 Rx_dval,
  output logic                 Rx_idle,
  output logic                 Rx_ferr,
  output logic                 Rx_perr
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] HALF  = CW'(CLKS_PER_BIT / 2);
  localparam logic [CW-1:0] LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] DLAST = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] SLAST = BW'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  state_t               state_q, state_d;
  logic                 rx_meta_q, rx_meta_d;
  logic                 rx_s_q, rx_s_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 ferr_acc_q, ferr_acc_d;
  logic                 armed_q, armed_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 dval_q, dval_d;
  logic                 idle_q, idle_d;
  logic                 ferr_q, ferr_d;
`ifdef UART_RX_PARITY_EN
  logic                 par_q, par_d;
  logic                 perr_q, perr_d;
`endif

  always_comb begin
    rx_meta_d  = Rx;
    rx_s_d     = rx_meta_q;
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_d      = bit_q;
    shift_d    = shift_q;
    ferr_acc_d = ferr_acc_q;
    // Once a frame starts, the line must be seen high again before another start bit (break handling).
    armed_d    = armed_q | rx_s_q;
    data_d     = data_q;
    dval_d     = 1'b0;
    ferr_d     = ferr_q;
`ifdef UART_RX_PARITY_EN
    par_d      = par_q;
    perr_d     = perr_q;
`endif
    case (state_q)
      S_IDLE: begin
        cnt_d      = '0;
        bit_d      = '0;
        ferr_acc_d = 1'b0;
        if (!rx_s_q && armed_q) begin
          state_d = S_START;
          armed_d = 1'b0;
        end
      end
      S_START: begin
        if (cnt_q == HALF) begin
          cnt_d   = '0;
          state_d = rx_s_q ? S_IDLE : S_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DATA: begin
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          shift_d = {rx_s_q, shift_q[DATA_BITS-1:1]};
          if (bit_q == DLAST) begin
            bit_d = '0;
`ifdef UART_RX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          par_d   = rx_s_q;
          state_d = S_STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`endif
      S_STOP: begin
        if (cnt_q == LAST) begin
          cnt_d = '0;
          if (!rx_s_q) ferr_acc_d = 1'b1;
          if (bit_q == SLAST) begin
            bit_d   = '0;
            state_d = S_DONE;
            dval_d  = 1'b1;
            data_d  = shift_q;
            ferr_d  = ferr_acc_q | ~rx_s_q;
`ifdef UART_RX_PARITY_EN
            perr_d  = (^{shift_q, par_q}) ^ PARITY_ODD[0];
`endif
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    idle_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta_q  <= 1'b1;
      rx_s_q     <= 1'b1;
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      ferr_acc_q <= 1'b0;
      armed_q    <= 1'b1;
      data_q     <= '0;
      dval_q     <= 1'b0;
      idle_q     <= 1'b1;
      ferr_q     <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q      <= 1'b0;
      perr_q     <= 1'b0;
`endif
    end else begin
      rx_meta_q  <= rx_meta_d;
      rx_s_q     <= rx_s_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      ferr_acc_q <= ferr_acc_d;
      armed_q    <= armed_d;
      data_q     <= data_d;
      dval_q     <= dval_d;
      idle_q     <= idle_d;
      ferr_q     <= ferr_d;
`ifdef UART_RX_PARITY_EN
      par_q      <= par_d;
      perr_q     <= perr_d;
`endif
    end
  end

  assign Rx_data = data_q;
  assign Rx_dval = dval_q;
  assign Rx_idle = idle_q;
  assign Rx_ferr = ferr_q;
`ifdef UART_RX_PARITY_EN
  assign Rx_perr = perr_q;
`else
  assign Rx_perr = 1'b0;
`endif

endmodule
